// File: rtl/axi4_lite_arbiter.sv
// Two-requester AXI4-lite arbiter onto one memory port, one outstanding transaction at a time.
// state | meaning: IDLE arbitrate | RADDR forward AR | RDATA forward R | WADDR forward AW+W | WRESP forward B
module axi4_lite_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_axi_awvalid,
    input  logic [31:0] m0_axi_awaddr,
    input  logic [2:0]  m0_axi_awprot,
    input  logic        m0_axi_wvalid,
    input  logic [31:0] m0_axi_wdata,
    input  logic [3:0]  m0_axi_wstrb,
    input  logic        m0_axi_bready,
    input  logic        m0_axi_arvalid,
    input  logic [31:0] m0_axi_araddr,
    input  logic [2:0]  m0_axi_arprot,
    input  logic        m0_axi_rready,
    output logic        m0_axi_awready,
    output logic        m0_axi_wready,
    output logic        m0_axi_bvalid,
    output logic        m0_axi_arready,
    output logic        m0_axi_rvalid,
    output logic [31:0] m0_axi_rdata,
    input  logic        m1_axi_awvalid,
    input  logic [31:0] m1_axi_awaddr,
    input  logic [2:0]  m1_axi_awprot,
    input  logic        m1_axi_wvalid,
    input  logic [31:0] m1_axi_wdata,
    input  logic [3:0]  m1_axi_wstrb,
    input  logic        m1_axi_bready,
    input  logic        m1_axi_arvalid,
    input  logic [31:0] m1_axi_araddr,
    input  logic [2:0]  m1_axi_arprot,
    input  logic        m1_axi_rready,
    output logic        m1_axi_awready,
    output logic        m1_axi_wready,
    output logic        m1_axi_bvalid,
    output logic        m1_axi_arready,
    output logic        m1_axi_rvalid,
    output logic [31:0] m1_axi_rdata,
    output logic        mem_axi_awvalid,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rready,
    input  logic        mem_axi_awready,
    input  logic        mem_axi_wready,
    input  logic        mem_axi_bvalid,
    input  logic        mem_axi_arready,
    input  logic        mem_axi_rvalid,
    input  logic [31:0] mem_axi_rdata,
    output logic        grant,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        elig0, elig1, pick;
    logic        aw_nxt, w_nxt;

    logic        g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    logic [31:0] g_awaddr, g_wdata, g_araddr;
    logic [2:0]  g_awprot, g_arprot;
    logic [3:0]  g_wstrb;
    logic        u_awready, u_wready, u_bvalid, u_arready, u_rvalid;
    logic [31:0] u_rdata;

    assign g_awvalid = grant_q ? m1_axi_awvalid : m0_axi_awvalid;
    assign g_awaddr  = grant_q ? m1_axi_awaddr  : m0_axi_awaddr;
    assign g_awprot  = grant_q ? m1_axi_awprot  : m0_axi_awprot;
    assign g_wvalid  = grant_q ? m1_axi_wvalid  : m0_axi_wvalid;
    assign g_wdata   = grant_q ? m1_axi_wdata   : m0_axi_wdata;
    assign g_wstrb   = grant_q ? m1_axi_wstrb   : m0_axi_wstrb;
    assign g_bready  = grant_q ? m1_axi_bready  : m0_axi_bready;
    assign g_arvalid = grant_q ? m1_axi_arvalid : m0_axi_arvalid;
    assign g_araddr  = grant_q ? m1_axi_araddr  : m0_axi_araddr;
    assign g_arprot  = grant_q ? m1_axi_arprot  : m0_axi_arprot;
    assign g_rready  = grant_q ? m1_axi_rready  : m0_axi_rready;

    assign elig0 = m0_axi_arvalid | (m0_axi_awvalid & m0_axi_wvalid);
    assign elig1 = m1_axi_arvalid | (m1_axi_awvalid & m1_axi_wvalid);

    // Forwarding is gated by resetn so every output is quiet for the whole reset window.
    always_comb begin
        mem_axi_awvalid = 1'b0;
        mem_axi_awaddr  = '0;
        mem_axi_awprot  = '0;
        mem_axi_wvalid  = 1'b0;
        mem_axi_wdata   = '0;
        mem_axi_wstrb   = '0;
        mem_axi_bready  = 1'b0;
        mem_axi_arvalid = 1'b0;
        mem_axi_araddr  = '0;
        mem_axi_arprot  = '0;
        mem_axi_rready  = 1'b0;
        u_awready       = 1'b0;
        u_wready        = 1'b0;
        u_bvalid        = 1'b0;
        u_arready       = 1'b0;
        u_rvalid        = 1'b0;
        u_rdata         = '0;
        if (resetn) begin
            case (state_q)
                RADDR: begin
                    mem_axi_arvalid = g_arvalid;
                    mem_axi_araddr  = g_araddr;
                    mem_axi_arprot  = g_arprot;
                    u_arready       = mem_axi_arready;
                end
                RDATA: begin
                    mem_axi_rready = g_rready;
                    u_rvalid       = mem_axi_rvalid;
                    u_rdata        = mem_axi_rdata;
                end
                WADDR: begin
                    mem_axi_awvalid = g_awvalid & ~aw_done_q;
                    mem_axi_awaddr  = g_awaddr;
                    mem_axi_awprot  = g_awprot;
                    mem_axi_wvalid  = g_wvalid & ~w_done_q;
                    mem_axi_wdata   = g_wdata;
                    mem_axi_wstrb   = g_wstrb;
                    u_awready       = mem_axi_awready & ~aw_done_q;
                    u_wready        = mem_axi_wready & ~w_done_q;
                end
                WRESP: begin
                    mem_axi_bready = g_bready;
                    u_bvalid       = mem_axi_bvalid;
                end
                default: ;
            endcase
        end
    end

    assign m0_axi_awready = ~grant_q & u_awready;
    assign m0_axi_wready  = ~grant_q & u_wready;
    assign m0_axi_bvalid  = ~grant_q & u_bvalid;
    assign m0_axi_arready = ~grant_q & u_arready;
    assign m0_axi_rvalid  = ~grant_q & u_rvalid;
    assign m0_axi_rdata   = grant_q ? 32'h0 : u_rdata;
    assign m1_axi_awready = grant_q & u_awready;
    assign m1_axi_wready  = grant_q & u_wready;
    assign m1_axi_bvalid  = grant_q & u_bvalid;
    assign m1_axi_arready = grant_q & u_arready;
    assign m1_axi_rvalid  = grant_q & u_rvalid;
    assign m1_axi_rdata   = grant_q ? u_rdata : 32'h0;

    assign aw_nxt = aw_done_q | (mem_axi_awvalid & mem_axi_awready);
    assign w_nxt  = w_done_q | (mem_axi_wvalid & mem_axi_wready);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        pick      = grant_q;
        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    // On a tie the requester not served last wins.
                    pick    = (elig0 & elig1) ? ~grant_q : elig1;
                    grant_d = pick;
                    state_d = (pick ? m1_axi_arvalid : m0_axi_arvalid) ? RADDR : WADDR;
                end
            end
            RADDR: if (mem_axi_arvalid & mem_axi_arready) state_d = RDATA;
            RDATA: if (mem_axi_rvalid & mem_axi_rready) state_d = IDLE;
            WADDR: begin
                if (aw_nxt & w_nxt) begin
                    state_d   = WRESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_nxt;
                    w_done_d  = w_nxt;
                end
            end
            WRESP: if (mem_axi_bvalid & mem_axi_bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign grant = resetn ? grant_q : 1'b1;
    assign busy  = resetn & (state_q != IDLE);

endmodule
